// File: rtl/xrv_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : xrv_mem_arb
// Description : Two-requester arbiter for one single-port synchronous memory
//               with a 1-cycle read latency. Load/store traffic has priority
//               over instruction fetch. A bounded starvation counter gives
//               fetch the slot once STARVE_MAX consecutive data grants have
//               been issued while a fetch was waiting. A fetch flush kills
//               both new fetch grants and the fetch response in flight.
// Ports       : clk, rst               - clock, async active-high reset
//               if_req/if_addr         - fetch read request and word address
//               if_flush               - fetch-stage jump/flush
//               if_gnt/if_rvalid/if_rdata - fetch grant and response
//               d_req/d_we/d_be/d_addr/d_wdata - load/store request
//               d_gnt/d_rvalid/d_rdata - load/store grant and response
//               mem_*                  - memory port (mem_rdata one cycle
//                                        after mem_en)
// Revision    : 1.0 - initial release
// ============================================================================
module xrv_mem_arb #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        if_flush,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [3:0]  d_be,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   owner_t     r_owner;
   owner_t     w_owner_nxt;
   logic [3:0] r_starve;
   logic [3:0] w_starve_nxt;
   logic       w_fetch_ok;
   logic       w_fetch_win;

   // ------------------------------------------------------------------------
   // Combinational grant. Fetch only wins when data is idle or when fetch has
   // already waited through STARVE_MAX data grants; a flushing fetch never
   // wins, so data takes the slot in that case.
   // ------------------------------------------------------------------------
   assign w_fetch_ok  = if_req & ~if_flush;
   assign w_fetch_win = w_fetch_ok & (~d_req | (r_starve == C_STARVE_MAX));
   assign if_gnt      = ~rst & w_fetch_win;
   assign d_gnt       = ~rst & d_req & ~w_fetch_win;

   // Memory request mux: fetch is always a full-word read.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_be    = 4'h0;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      if (d_gnt) begin
         mem_en    = 1'b1;
         mem_we    = d_we;
         mem_be    = d_be;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end else if (if_gnt) begin
         mem_en    = 1'b1;
         mem_be    = 4'hF;
         mem_addr  = if_addr;
      end
   end

   // ------------------------------------------------------------------------
   // Owner tracking and starvation counter (next-state logic).
   // ------------------------------------------------------------------------
   always_comb begin
      w_owner_nxt  = OWN_NONE;
      w_starve_nxt = r_starve;
      if (d_gnt) begin
         w_owner_nxt = OWN_D;
      end else if (if_gnt) begin
         w_owner_nxt = OWN_IF;
      end

      // Counter only advances while a live (unflushed) fetch is being passed
      // over; any fetch grant, withdrawn request or flush restarts the count.
      if (if_gnt || !if_req || if_flush) begin
         w_starve_nxt = 4'h0;
      end else if (d_gnt) begin
         if (r_starve >= C_STARVE_MAX) begin
            w_starve_nxt = C_STARVE_MAX;
         end else begin
            w_starve_nxt = r_starve + 4'h1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner  <= OWN_NONE;
         r_starve <= 4'h0;
      end else begin
         r_owner  <= w_owner_nxt;
         r_starve <= w_starve_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Responses. The owner register is cleared asynchronously by reset, so an
   // access in flight when reset hits never produces a response. A flush in
   // the response cycle suppresses the stale fetch data.
   // ------------------------------------------------------------------------
   assign d_rvalid  = (r_owner == OWN_D);
   assign if_rvalid = (r_owner == OWN_IF) & ~if_flush;
   assign d_rdata   = d_rvalid  ? mem_rdata : 32'h0;
   assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_xrv_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_xrv_mem_arb
// Description : Self-checking bench for xrv_mem_arb. A behavioural memory
//               model sits on the mem_* port; a cycle-level reference model
//               (grant rules, starvation count, shadow memory) predicts every
//               output of every cycle for directed and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xrv_mem_arb;

   localparam int SMAX = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_flush;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [3:0]  d_be;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   xrv_mem_arb #(.STARVE_MAX(SMAX)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_flush  (if_flush),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_be      (d_be),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   function automatic logic [31:0] init_word(input int i);
      return 32'hA500_0000 ^ (i * 32'h0001_0203);
   endfunction

   // Behavioural memory: read-first, byte-enabled writes, 1-cycle latency.
   // Returns junk when idle so response gating is exercised.
   logic [31:0] mem [0:255];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
         mem_rdata <= $urandom;
      end else if (mem_en) begin
         mem_rdata <= mem[mem_addr[7:0]];
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end else begin
         mem_rdata <= $urandom;
      end
   end

   // Reference model state
   logic [31:0] m_mem [0:255];
   int          m_starve = 0;
   int          m_owner  = 0;   // 0 none, 1 fetch, 2 data
   logic [31:0] m_rdata  = 32'h0;
   logic        last_if_gnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check every output against the model,
   // then advance the model.
   task automatic cycle(input logic r, input logic iq, input logic [31:0] ia,
                        input logic fl, input logic dq, input logic we,
                        input logic [3:0] be, input logic [31:0] da,
                        input logic [31:0] dw);
      int          g;
      logic [7:0]  idx;
      logic        exp_ifv, exp_dv;
      @(posedge clk);
      #1;
      rst = r; if_req = iq; if_addr = ia; if_flush = fl;
      d_req = dq; d_we = we; d_be = be; d_addr = da; d_wdata = dw;
      #3;
      if (r) g = 0;
      else if (iq && !fl && (!dq || m_starve == SMAX)) g = 1;
      else if (dq) g = 2;
      else g = 0;

      chk("if_gnt", {31'h0, if_gnt}, {31'h0, g == 1});
      chk("d_gnt",  {31'h0, d_gnt},  {31'h0, g == 2});
      chk("mem_en", {31'h0, mem_en}, {31'h0, g != 0});
      chk("mem_we", {31'h0, mem_we}, {31'h0, g == 2 && we});
      chk("mem_be", {28'h0, mem_be}, {28'h0, (g == 1) ? 4'hF : (g == 2) ? be : 4'h0});
      chk("mem_addr", mem_addr, (g == 1) ? ia : (g == 2) ? da : 32'h0);
      if (g != 1) chk("mem_wdata", mem_wdata, (g == 2) ? dw : 32'h0);

      exp_dv  = !r && m_owner == 2;
      exp_ifv = !r && m_owner == 1 && !fl;
      chk("d_rvalid",  {31'h0, d_rvalid},  {31'h0, exp_dv});
      chk("if_rvalid", {31'h0, if_rvalid}, {31'h0, exp_ifv});
      chk("d_rdata",  d_rdata,  exp_dv  ? m_rdata : 32'h0);
      chk("if_rdata", if_rdata, exp_ifv ? m_rdata : 32'h0);
      last_if_gnt = if_gnt;

      if (r) begin
         m_starve = 0;
         m_owner  = 0;
         for (int i = 0; i < 256; i++) m_mem[i] = init_word(i);
      end else begin
         idx = (g == 1) ? ia[7:0] : da[7:0];
         if (g != 0) m_rdata = m_mem[idx];
         if (g == 2 && we) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) m_mem[idx][8*b +: 8] = dw[8*b +: 8];
         end
         m_owner = g;
         if (g == 1 || !iq || fl) m_starve = 0;
         else if (g == 2 && m_starve < SMAX) m_starve++;
      end
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   initial begin
      logic [31:0] pat;
      rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
      d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;

      // Reset state
      repeat (3) cycle(1'b1, 1'b1, 32'h44, 1'b0, 1'b1, 1'b1, 4'hF, 32'h8, 32'h1234);

      // Fetch only, three back-to-back cycles; first grant right after release
      repeat (3) cycle(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      idle();

      // Idle: memory port quiet
      repeat (3) idle();

      // Starvation: both requesting, expect 4:1 data:fetch pattern
      pat = 32'h0;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 1'b1, 32'h40 + 32'(i), 1'b0, 1'b1, 1'b0, 4'hF, 32'h80 + 32'(i), 32'h0);
         pat[i] = last_if_gnt;
      end
      chk("starve_pattern", pat, 32'h0000_0210);
      idle();

      // Store with partial byte enables, then read it back
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h2000, 32'hDEADBEEF);
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0);
      idle();

      // Flush: fetch granted, then flush while fetch request held
      cycle(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      cycle(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      cycle(1'b0, 1'b1, 32'h304, 1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
      cycle(1'b0, 1'b1, 32'h304, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      idle();

      // Reset mid-flight: load granted, reset pulsed, response discarded
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
      cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      repeat (2) idle();

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 63) == 0),
               ($urandom_range(0, 3) != 0),
               {$urandom_range(0, 15), 4'h0, 8'($urandom)},
               ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 9) < 6),
               1'($urandom),
               4'($urandom),
               {$urandom_range(0, 15), 4'h0, 8'($urandom)},
               $urandom);
      end
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/xrv_mem_arb.md
XRV_MEM_ARB -- requirements
Module: xrv_mem_arb

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 4, meaning the maximum consecutive data grants while a fetch request waits (range 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port if_req, input, 1, instruction-fetch read request.
REQ-005 The block SHALL have port if_addr, input, 32, fetch word address.
REQ-006 The block SHALL have port if_flush, input, 1, jump/flush from fetch stage; kills fetch traffic.
REQ-007 The block SHALL have ports if_gnt (output, 1, fetch accepted this cycle), if_rvalid (output, 1, fetch data valid) and if_rdata (output, 32, fetch read data).
REQ-008 The block SHALL have port d_req, input, 1, load/store request.
REQ-009 The block SHALL have ports d_we (input, 1, write), d_be (input, 4, byte enables), d_addr (input, 32) and d_wdata (input, 32).
REQ-010 The block SHALL have ports d_gnt (output, 1), d_rvalid (output, 1, load data or store completion) and d_rdata (output, 32).
REQ-011 The block SHALL have ports mem_en, mem_we (outputs, 1), mem_be (output, 4), mem_addr and mem_wdata (outputs, 32) and mem_rdata (input, 32), driving a single-port synchronous memory with 1-cycle read latency.

Function
REQ-012 Grant SHALL be combinational; at most one of if_gnt/d_gnt high per cycle; no grant while rst high.
REQ-013 Priority: data over fetch, except when starve_cnt == STARVE_MAX and if_req high and if_flush low, then fetch wins.
REQ-014 if_gnt SHALL be 0 whenever if_flush is 1.
REQ-015 starve_cnt (4 bits): +1 when d_gnt && if_req && !if_flush; cleared when if_gnt or !if_req or if_flush; saturates at STARVE_MAX.
REQ-016 mem_en = if_gnt | d_gnt; mem_addr/mem_we/mem_be/mem_wdata muxed from the winner; mem_we = 0, mem_be = 4'hF on fetch grant; all mem outputs 0 when no grant.
REQ-017 Owner pipeline register (NONE/IF/D) SHALL record the granted requester; the response SHALL be exactly 1 cycle after grant.
REQ-018 d_rvalid SHALL pulse 1 cycle after every d_gnt (loads and stores); d_rdata = mem_rdata when d_rvalid, else 0.
REQ-019 if_rvalid SHALL pulse 1 cycle after if_gnt unless if_flush was high in the response cycle; if_rdata = mem_rdata when if_rvalid, else 0.
REQ-020 Back-to-back grants SHALL be allowed every cycle (throughput 1 access/cycle, alternating owners allowed).
REQ-021 Simultaneous d_req and if_req with if_flush high: data granted, starve_cnt cleared.
REQ-022 Requesters SHALL hold req/addr/data stable until granted; the block SHALL not queue requests.

Reset
REQ-023 While rst is high: if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we = 0; mem_be, mem_addr, mem_wdata, if_rdata, d_rdata = 0; starve_cnt = 0; owner = NONE.
REQ-024 Reset asserted mid-operation SHALL discard the outstanding response (no rvalid in the cycle after reset release).
REQ-025 First grant possible in the first cycle with rst low.

Verification
REQ-026 Fetch only: if_req=1, if_addr=0x100 for 3 cycles -> if_gnt 3 cycles, mem_addr 0x100, if_rvalid at cycles 1..3 with if_rdata = mem_rdata.
REQ-027 Starvation: d_req and if_req held high, STARVE_MAX=4 -> d_gnt 4 cycles, if_gnt in cycle 5, d_gnt resumes cycle 6; repeating 4:1 pattern.
REQ-028 Store: d_req=1, d_we=1, d_be=4'b0011, d_addr=0x2000, d_wdata=0xDEADBEEF -> mem_en=1, mem_we=1, mem_be=4'b0011 same cycle; d_rvalid next cycle.
REQ-029 Flush: if_gnt in cycle N, if_flush=1 in cycle N+1 -> if_rvalid stays 0 in N+1; if_gnt=0 during flush while if_req held.
REQ-030 Reset mid-flight: d_gnt for a load in cycle N, rst pulsed in N+1 -> d_rvalid 0, all outputs 0, starve_cnt 0 after release.
REQ-031 Idle: no requests -> mem_en=0 and all mem outputs 0 every cycle.
